// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared fetch-stage types
package fetch_unit_pkg;
   typedef logic [31:0] enc_t;
   typedef logic [31:0] pc_t;
   typedef struct packed {
      enc_t enc;
      pc_t  pc;
      logic fault;
   } fetch_entry_t;
   localparam pc_t PC_STEP = 32'd4;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO of fetch entries with flush
module fetch_queue
   import fetch_unit_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int CW = $clog2(DEPTH + 1),
   localparam int AW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  fetch_entry_t  din,
   output fetch_entry_t  dout,
   output logic [CW-1:0] count,
   output logic          empty,
   output logic          full
);
   fetch_entry_t  mem [DEPTH];
   logic [AW-1:0] rd, wr;
   logic          do_push, do_pop;
   assign empty   = count == '0;
   assign full    = count == CW'(DEPTH);
   assign do_push = push && !flush;
   assign do_pop  = pop && !empty && !flush;
   assign dout    = empty ? '0 : mem[rd];
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         rd    <= '0;
         wr    <= '0;
         count <= '0;
      end else if (flush) begin
         rd    <= '0;
         wr    <= '0;
         count <= '0;
      end else begin
         if (do_push) wr <= wr + 1'b1;
         if (do_pop) rd <= rd + 1'b1;
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   always_ff @(posedge clk)
      if (do_push) mem[wr] <= din;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner issuing word fetches and queueing responses for decode
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          QDEPTH   = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        redirectValid,
   input  logic [31:0] redirectPc,
   output logic        imemReqValid,
   input  logic        imemReqReady,
   output logic [31:0] imemReqAddr,
   input  logic        imemRspValid,
   input  logic [31:0] imemRspData,
   input  logic        imemRspErr,
   output logic        outValid,
   input  logic        outReady,
   output logic [31:0] outEnc,
   output logic [31:0] outPc,
   output logic        outFault
);
   localparam int CW = $clog2(QDEPTH + 1);
   pc_t           pc, rsp_pc, redirect_pc;
   logic [CW-1:0] inflight, drop, count;
   logic          halted, req_fire, rsp_drop, push, empty, full, unused_lsb;
   fetch_entry_t  head;
   assign redirect_pc  = {redirectPc[31:2], 2'b00};
   assign unused_lsb   = ^redirectPc[1:0];
   // credits cover both outstanding requests and queued entries, so responses never need backpressure
   assign imemReqValid = rst_n && !redirectValid && !halted &&
                         ({1'b0, inflight} + {1'b0, count} < (CW + 1)'(QDEPTH));
   assign imemReqAddr  = pc;
   assign req_fire     = imemReqValid && imemReqReady;
   assign rsp_drop     = drop != '0;
   assign push         = imemRspValid && !rsp_drop && !redirectValid;
   assign outValid     = !empty;
   assign outEnc       = head.enc;
   assign outPc        = head.pc;
   assign outFault     = head.fault;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         pc       <= RESET_PC;
         rsp_pc   <= RESET_PC;
         inflight <= '0;
         drop     <= '0;
         halted   <= 1'b0;
      end else begin
         inflight <= inflight + CW'(req_fire) - CW'(imemRspValid);
         if (redirectValid) begin
            pc     <= redirect_pc;
            rsp_pc <= redirect_pc;
            halted <= 1'b0;
            drop   <= inflight - CW'(imemRspValid);
         end else begin
            if (req_fire) pc <= pc + PC_STEP;
            if (push) rsp_pc <= rsp_pc + PC_STEP;
            if (push && imemRspErr) halted <= 1'b1;
            drop <= drop - CW'(imemRspValid && rsp_drop);
         end
      end
   fetch_queue #(.DEPTH(QDEPTH)) u_queue (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (outValid && outReady),
      .flush (redirectValid),
      .din   ('{enc: imemRspData, pc: rsp_pc, fault: imemRspErr}),
      .dout  (head),
      .count (count),
      .empty (empty),
      .full  (full)
   );
   a_rsp_credit: assert property (@(posedge clk) disable iff (!rst_n) imemRspValid |-> inflight != '0);
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) push |-> !full);
   a_drop_bound: assert property (@(posedge clk) disable iff (!rst_n) drop <= inflight);
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scoreboard bench for fetch_unit
module tb_fetch_unit;
   import fetch_unit_pkg::*;
   logic        clk = 0, rst_n = 0, redirectValid = 0, imemReqReady = 0, outReady = 1;
   logic [31:0] redirectPc = 0, imemRspData = 0;
   logic        imemRspValid = 0, imemRspErr = 0;
   logic        imemReqValid, outValid, outFault;
   logic [31:0] imemReqAddr, outEnc, outPc;
   int          cyc = 0, n_chk = 0, n_fail = 0, lat = 1, first_req = -1, first_out = -1;
   logic [31:0] err_addr = 32'h1, exp_addr = 0, mem_a;
   logic        mem_fire;
   fetch_entry_t exp_q[$];
   fetch_entry_t e;
   int          due_q[$];
   logic [31:0] addr_q[$];

   fetch_unit #(.RESET_PC(32'h0), .QDEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .redirectValid(redirectValid), .redirectPc(redirectPc),
      .imemReqValid(imemReqValid), .imemReqReady(imemReqReady), .imemReqAddr(imemReqAddr),
      .imemRspValid(imemRspValid), .imemRspData(imemRspData), .imemRspErr(imemRspErr),
      .outValid(outValid), .outReady(outReady), .outEnc(outEnc), .outPc(outPc), .outFault(outFault)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(string name, logic [71:0] act, logic [71:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // in-order memory with fixed latency, data = addr + 0x13
   initial forever begin
      @(negedge clk);
      mem_fire = rst_n && imemReqValid && imemReqReady;
      mem_a = imemReqAddr;
      @(posedge clk); #1;
      if (!rst_n) begin
         due_q.delete(); addr_q.delete(); imemRspValid = 0;
      end else begin
         if (mem_fire) begin due_q.push_back(cyc - 1 + lat); addr_q.push_back(mem_a); end
         if (due_q.size() != 0 && due_q[0] <= cyc) begin
            void'(due_q.pop_front());
            mem_a = addr_q.pop_front();
            imemRspValid = 1; imemRspData = mem_a + 32'h13; imemRspErr = mem_a == err_addr;
         end else imemRspValid = 0;
      end
   end

   always @(negedge clk) if (rst_n && outValid) begin
      if (first_out < 0) first_out = cyc;
      if (outReady) begin
         if (exp_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_out: got pc %h expected no output", outPc);
         end else begin
            e = exp_q.pop_front();
            chk("out_entry", 72'({outEnc, outPc, outFault}), 72'(e));
         end
      end
   end

   task automatic issue(int n, bit keep);
      imemReqReady = 1;
      repeat (n) begin
         @(negedge clk);
         if (first_req < 0) first_req = cyc;
         chk("req_addr", 72'({imemReqValid, imemReqAddr}), 72'({1'b1, exp_addr}));
         if (keep) exp_q.push_back(fetch_entry_t'{enc: exp_addr + 32'h13, pc: exp_addr, fault: exp_addr == err_addr});
         exp_addr += 4;
         @(posedge clk); #1;
      end
      imemReqReady = 0;
   endtask

   task automatic no_req(int n, string name);
      imemReqReady = 1;
      repeat (n) begin
         @(negedge clk);
         chk(name, 72'(imemReqValid), 72'd0);
         @(posedge clk); #1;
      end
      imemReqReady = 0;
   endtask

   task automatic redirect(logic [31:0] a);
      redirectValid = 1; redirectPc = a; imemReqReady = 1;
      @(negedge clk);
      chk("redirect_noreq", 72'(imemReqValid), 72'd0);
      @(posedge clk); #1;
      redirectValid = 0; imemReqReady = 0;
      exp_addr = a & 32'hFFFF_FFFC;
   endtask

   task automatic drain();
      int k = 0;
      while (exp_q.size() != 0 && k < 200) begin @(posedge clk); k++; end
      chk("drain", 72'(exp_q.size()), 72'd0);
      repeat (4) @(posedge clk);
      #1;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_state", 72'({outValid, imemReqValid, outEnc, outPc, outFault}), 72'd0);
      @(posedge clk); #2; rst_n = 1;
      issue(4, 1); drain();
      chk("first_latency", 72'(first_out - first_req), 72'd2);
      outReady = 0; issue(4, 1); no_req(3, "credit_stall");
      outReady = 1;
      @(negedge clk); chk("full_noreq", 72'(imemReqValid), 72'd0);
      @(posedge clk); #1;
      issue(2, 1); drain();
      lat = 3; issue(2, 0); redirect(32'h100); issue(2, 1); drain();
      lat = 1; err_addr = 32'h8; redirect(32'h0); issue(3, 1);
      @(posedge clk); #1;
      no_req(4, "halted_noreq"); drain();
      err_addr = 32'h1; redirect(32'h40); issue(2, 1); drain();
      redirect(32'hFFFF_FFFF); issue(2, 1); drain();
      outReady = 0; issue(2, 0);
      @(posedge clk); #1;
      lat = 3; issue(2, 0);
      #1; chk("pre_reset_valid", 72'(outValid), 72'd1);
      rst_n = 0;
      #1; chk("async_reset", 72'({outValid, imemReqValid, outPc}), 72'd0);
      repeat (2) @(posedge clk);
      #2; rst_n = 1; lat = 1; outReady = 1; exp_addr = 32'h0;
      issue(2, 1); drain();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1);
   end
endmodule
